// File: rtl/user_io_debounce_led_if.sv
// user_io_debounce_led_if: board-side pins and debounced user-logic signals of the user I/O controller
interface user_io_debounce_led_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] USER_DIPSW_FPGA;
  logic [NUM_CH-1:0] USER_PB_FPGA;
  logic [NUM_CH-1:0] USER_LED_FPGA;
  logic [NUM_CH-1:0] dipsw_db_o;
  logic [NUM_CH-1:0] pb_pulse_o;
  logic [2*NUM_CH-1:0] mode_o;
  modport master (
    output USER_DIPSW_FPGA, USER_PB_FPGA,
    input  USER_LED_FPGA, dipsw_db_o, pb_pulse_o, mode_o
  );
  modport slave (
    input  USER_DIPSW_FPGA, USER_PB_FPGA,
    output USER_LED_FPGA, dipsw_db_o, pb_pulse_o, mode_o
  );
endinterface

// File: rtl/user_io_debounce_led.sv
// user_io_debounce_led: debounces DIP switches and push-buttons and drives per-channel mode-controlled user LEDs
module user_io_debounce_led #(
  parameter int NUM_CH            = 4,
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int BLINK_HALF_CYCLES = 12500000,
  parameter int PWM_W             = 4,
  parameter int PWM_DUTY          = 4,
  parameter bit LED_ACTIVE_LOW    = 1'b1
) (
  input logic                  CLK_50M_FPGA,
  input logic                  GLOBAL_RESETN,
  user_io_debounce_led_if.slave io
);
  localparam int N2 = 2 * NUM_CH;
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int BW = BLINK_HALF_CYCLES > 1 ? $clog2(BLINK_HALF_CYCLES) : 1;
  localparam logic [N2-1:0] RST_V = {{NUM_CH{1'b1}}, {NUM_CH{1'b0}}};
  typedef enum logic [1:0] {DIRECT = 2'b00, BLINK = 2'b01, PWM = 2'b10, OFF = 2'b11} mode_e;
  logic [N2-1:0] sync1_q, sync2_q, stb_q, stb_d, diff, last;
  logic [DW-1:0] cnt_q [N2];
  logic [DW-1:0] cnt_d [N2];
  logic [NUM_CH-1:0] pulse_q, pulse_d, led_q, led_d, db;
  mode_e mode_q [NUM_CH];
  mode_e mode_d [NUM_CH];
  logic [BW-1:0] blink_q, blink_d;
  logic phase_q, phase_d, blink_wrap;
  logic [PWM_W-1:0] pwm_q, pwm_d;
  logic pwm_on;
  assign db = stb_q[NUM_CH-1:0];
  assign diff = sync2_q ^ stb_q;
  assign blink_wrap = blink_q == BW'(BLINK_HALF_CYCLES - 1);
  assign pwm_on = {1'b0, pwm_q} < (PWM_W + 1)'(PWM_DUTY);
  always_comb begin
    for (int i = 0; i < N2; i++) begin
      last[i] = cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1);
      stb_d[i] = diff[i] && last[i] ? sync2_q[i] : stb_q[i];
      cnt_d[i] = diff[i] && !last[i] ? cnt_q[i] + 1'b1 : '0;
    end
    pulse_d = stb_q[N2-1:NUM_CH] & ~stb_d[N2-1:NUM_CH];
    for (int i = 0; i < NUM_CH; i++) begin
      mode_d[i] = pulse_q[i] ? mode_e'(mode_q[i] + 2'd1) : mode_q[i];
      led_d[i] = mode_q[i] == DIRECT ? db[i] :
                 mode_q[i] == BLINK  ? db[i] & phase_q :
                 mode_q[i] == PWM    ? db[i] & pwm_on : 1'b0;
    end
    blink_d = blink_wrap ? '0 : blink_q + 1'b1;
    phase_d = phase_q ^ blink_wrap;
    pwm_d = pwm_q + 1'b1;
  end
  always_ff @(posedge CLK_50M_FPGA or negedge GLOBAL_RESETN) begin
    if (!GLOBAL_RESETN) begin
      sync1_q <= RST_V;
      sync2_q <= RST_V;
      stb_q <= RST_V;
      for (int i = 0; i < N2; i++) cnt_q[i] <= '0;
      for (int i = 0; i < NUM_CH; i++) mode_q[i] <= DIRECT;
      pulse_q <= '0;
      led_q <= '0;
      blink_q <= '0;
      phase_q <= 1'b0;
      pwm_q <= '0;
    end else begin
      sync1_q <= {io.USER_PB_FPGA, io.USER_DIPSW_FPGA};
      sync2_q <= sync1_q;
      stb_q <= stb_d;
      cnt_q <= cnt_d;
      mode_q <= mode_d;
      pulse_q <= pulse_d;
      led_q <= led_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      pwm_q <= pwm_d;
    end
  end
  assign io.dipsw_db_o = db;
  assign io.pb_pulse_o = pulse_q;
  assign io.USER_LED_FPGA = led_q ^ {NUM_CH{LED_ACTIVE_LOW}};
  for (genvar g = 0; g < NUM_CH; g++) begin : g_mode
    assign io.mode_o[2*g+:2] = mode_q[g];
  end
endmodule

// File: tb/tb_user_io_debounce_led.sv
// tb_user_io_debounce_led: directed and randomized checks of the user I/O controller against a behavioural model
module tb_user_io_debounce_led;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [3:0] dip = 4'h0;
  logic [3:0] pb = 4'hF;
  int vectors = 0;
  int errors = 0;
  always #5 clk = ~clk;
  user_io_debounce_led_if #(.NUM_CH(4)) if0 ();
  user_io_debounce_led_if #(.NUM_CH(4)) if1 ();
  user_io_debounce_led_if #(.NUM_CH(4)) if2 ();
  assign if0.USER_DIPSW_FPGA = dip;
  assign if1.USER_DIPSW_FPGA = dip;
  assign if2.USER_DIPSW_FPGA = dip;
  assign if0.USER_PB_FPGA = pb;
  assign if1.USER_PB_FPGA = pb;
  assign if2.USER_PB_FPGA = pb;
  user_io_debounce_led #(.NUM_CH(4), .DEBOUNCE_CYCLES(8), .BLINK_HALF_CYCLES(4), .PWM_W(3), .PWM_DUTY(2), .LED_ACTIVE_LOW(1'b1))
    dut0 (.CLK_50M_FPGA(clk), .GLOBAL_RESETN(rst_n), .io(if0.slave));
  user_io_debounce_led #(.NUM_CH(4), .DEBOUNCE_CYCLES(8), .BLINK_HALF_CYCLES(4), .PWM_W(3), .PWM_DUTY(0), .LED_ACTIVE_LOW(1'b1))
    dut1 (.CLK_50M_FPGA(clk), .GLOBAL_RESETN(rst_n), .io(if1.slave));
  user_io_debounce_led #(.NUM_CH(4), .DEBOUNCE_CYCLES(8), .BLINK_HALF_CYCLES(4), .PWM_W(3), .PWM_DUTY(8), .LED_ACTIVE_LOW(1'b1))
    dut2 (.CLK_50M_FPGA(clk), .GLOBAL_RESETN(rst_n), .io(if2.slave));
  logic [7:0] hq [$];
  logic [7:0] smp;
  logic [3:0] m_db, m_pb, m_pulse, nds, nps;
  logic [3:0] m_led [3];
  int m_mode [4];
  int drun [4];
  int prun [4];
  int duty [3] = '{2, 0, 8};
  int n;
  logic phase;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0;
      hq = {8'hF0, 8'hF0};
      m_db = 4'h0;
      m_pb = 4'hF;
      m_pulse = 4'h0;
      for (int i = 0; i < 4; i++) begin
        m_mode[i] = 0;
        drun[i] = 0;
        prun[i] = 0;
      end
      for (int d = 0; d < 3; d++) m_led[d] = 4'h0;
    end else begin
      smp = hq.pop_front();
      hq.push_back({pb, dip});
      phase = ((n / 4) % 2) == 1;
      for (int d = 0; d < 3; d++)
        for (int i = 0; i < 4; i++)
          m_led[d][i] = m_mode[i] == 0 ? m_db[i] :
                        m_mode[i] == 1 ? (m_db[i] & phase) :
                        m_mode[i] == 2 ? (m_db[i] && (n % 8) < duty[d]) : 1'b0;
      for (int i = 0; i < 4; i++) if (m_pulse[i]) m_mode[i] = (m_mode[i] + 1) % 4;
      nds = m_db;
      nps = m_pb;
      for (int i = 0; i < 4; i++) begin
        if (smp[i] !== m_db[i]) begin
          drun[i]++;
          if (drun[i] == 8) begin nds[i] = smp[i]; drun[i] = 0; end
        end else drun[i] = 0;
        if (smp[i+4] !== m_pb[i]) begin
          prun[i]++;
          if (prun[i] == 8) begin nps[i] = smp[i+4]; prun[i] = 0; end
        end else prun[i] = 0;
      end
      m_pulse = m_pb & ~nps;
      m_db = nds;
      m_pb = nps;
      n++;
    end
  end
  task automatic press(input int ch, output int cnt);
    cnt = 0;
    pb[ch] = 1'b0;
    repeat (14) begin @(negedge clk); cnt += int'(if0.pb_pulse_o[ch]); end
    pb[ch] = 1'b1;
    repeat (14) begin @(negedge clk); cnt += int'(if0.pb_pulse_o[ch]); end
  endtask
  task automatic test_reset;
    #1 rst_n = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      dip = 4'($urandom);
      pb = 4'($urandom);
      vectors++;
      if (if0.USER_LED_FPGA !== 4'hF || if1.USER_LED_FPGA !== 4'hF || if2.USER_LED_FPGA !== 4'hF) begin
        errors++;
        $display("FAIL rst_led: got %h/%h/%h expected f", if0.USER_LED_FPGA, if1.USER_LED_FPGA, if2.USER_LED_FPGA);
      end
      vectors++;
      if (if0.mode_o !== 8'h00) begin errors++; $display("FAIL rst_mode: got %h expected 00", if0.mode_o); end
      vectors++;
      if (if0.pb_pulse_o !== 4'h0) begin errors++; $display("FAIL rst_pulse: got %h expected 0", if0.pb_pulse_o); end
      vectors++;
      if (if0.dipsw_db_o !== 4'h0) begin errors++; $display("FAIL rst_db: got %h expected 0", if0.dipsw_db_o); end
    end
    dip = 4'h0;
    pb = 4'hF;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask
  task automatic test_debounce_dip;
    dip[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      vectors++;
      if (if0.dipsw_db_o[0] !== (k == 10)) begin
        errors++;
        $display("FAIL dip0_latency edge %0d: got %b expected %b", k, if0.dipsw_db_o[0], k == 10);
      end
    end
    vectors++;
    if (if0.USER_LED_FPGA[0] !== 1'b1) begin errors++; $display("FAIL led0_early: got %b expected 1", if0.USER_LED_FPGA[0]); end
    @(negedge clk);
    vectors++;
    if (if0.USER_LED_FPGA[0] !== 1'b0) begin errors++; $display("FAIL led0_on: got %b expected 0", if0.USER_LED_FPGA[0]); end
    dip[1] = 1'b1;
    repeat (7) @(negedge clk);
    dip[1] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      vectors++;
      if (if0.dipsw_db_o[1] !== 1'b0) begin errors++; $display("FAIL dip1_glitch cycle %0d: got 1 expected 0", k); end
    end
  endtask
  task automatic test_button;
    int pulses, first, c;
    pulses = 0;
    first = -1;
    pb[2] = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (if0.pb_pulse_o[2]) begin pulses++; if (first < 0) first = k; end
      if (k == 10) begin
        vectors++;
        if (if0.mode_o[5:4] !== 2'b00) begin errors++; $display("FAIL mode2_before: got %b expected 00", if0.mode_o[5:4]); end
      end
      if (k == 11) begin
        vectors++;
        if (if0.mode_o[5:4] !== 2'b01) begin errors++; $display("FAIL mode2_step: got %b expected 01", if0.mode_o[5:4]); end
      end
      if (k == 20) pb[2] = 1'b1;
    end
    vectors++;
    if (pulses != 1) begin errors++; $display("FAIL pb2_pulses: got %0d expected 1", pulses); end
    vectors++;
    if (first != 10) begin errors++; $display("FAIL pb2_latency: got %0d expected 10", first); end
    for (int p = 0; p < 3; p++) begin
      press(2, c);
      vectors++;
      if (c != 1) begin errors++; $display("FAIL pb2_press%0d: got %0d pulses expected 1", p, c); end
    end
    vectors++;
    if (if0.mode_o[5:4] !== 2'b00) begin errors++; $display("FAIL mode2_wrap: got %b expected 00", if0.mode_o[5:4]); end
  endtask
  task automatic test_blink;
    int c, nch, last, bad;
    logic v, prev;
    press(2, c);
    vectors++;
    if (if0.mode_o[5:4] !== 2'b01) begin errors++; $display("FAIL blink_mode: got %b expected 01", if0.mode_o[5:4]); end
    dip[2] = 1'b1;
    repeat (14) @(negedge clk);
    nch = 0;
    last = -1;
    bad = 0;
    prev = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      v = if0.USER_LED_FPGA[2];
      if (k > 0 && v !== prev) begin
        nch++;
        if (last >= 0 && k - last != 4) bad++;
        last = k;
      end
      prev = v;
    end
    vectors++;
    if (nch != 6) begin errors++; $display("FAIL blink_toggles: got %0d expected 6", nch); end
    vectors++;
    if (bad != 0) begin errors++; $display("FAIL blink_period: got %0d bad intervals expected 0", bad); end
    dip[2] = 1'b0;
    repeat (12) @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      vectors++;
      if (if0.USER_LED_FPGA[2] !== 1'b1) begin errors++; $display("FAIL blink_off cycle %0d: got 0 expected 1", k); end
    end
  endtask
  task automatic test_pwm;
    int c, l0, l1, l2;
    press(3, c);
    press(3, c);
    vectors++;
    if (if0.mode_o[7:6] !== 2'b10) begin errors++; $display("FAIL pwm_mode: got %b expected 10", if0.mode_o[7:6]); end
    dip[3] = 1'b1;
    repeat (14) @(negedge clk);
    for (int w = 0; w < 4; w++) begin
      l0 = 0; l1 = 0; l2 = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        l0 += int'(!if0.USER_LED_FPGA[3]);
        l1 += int'(!if1.USER_LED_FPGA[3]);
        l2 += int'(!if2.USER_LED_FPGA[3]);
      end
      vectors++;
      if (l0 != 2) begin errors++; $display("FAIL pwm_duty2 win %0d: got %0d lit expected 2", w, l0); end
      vectors++;
      if (l1 != 0) begin errors++; $display("FAIL pwm_duty0 win %0d: got %0d lit expected 0", w, l1); end
      vectors++;
      if (l2 != 8) begin errors++; $display("FAIL pwm_duty8 win %0d: got %0d lit expected 8", w, l2); end
    end
    press(3, c);
    vectors++;
    if (if0.mode_o[7:6] !== 2'b11) begin errors++; $display("FAIL off_mode: got %b expected 11", if0.mode_o[7:6]); end
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      if (k % 12 == 0) dip[3] = ~dip[3];
      vectors++;
      if ({if0.USER_LED_FPGA[3], if1.USER_LED_FPGA[3], if2.USER_LED_FPGA[3]} !== 3'b111) begin
        errors++;
        $display("FAIL off_led cycle %0d: got %b%b%b expected 111", k, if0.USER_LED_FPGA[3], if1.USER_LED_FPGA[3], if2.USER_LED_FPGA[3]);
      end
    end
    dip[3] = 1'b1;
  endtask
  task automatic test_reset_mid;
    int pulses, first;
    pb[1] = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (if0.USER_LED_FPGA !== 4'hF) begin errors++; $display("FAIL mid_rst_led: got %h expected f", if0.USER_LED_FPGA); end
    vectors++;
    if (if0.mode_o !== 8'h00) begin errors++; $display("FAIL mid_rst_mode: got %h expected 00", if0.mode_o); end
    vectors++;
    if (if0.dipsw_db_o !== 4'h0 || if0.pb_pulse_o !== 4'h0) begin
      errors++;
      $display("FAIL mid_rst_db_pulse: got %h/%h expected 0/0", if0.dipsw_db_o, if0.pb_pulse_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    first = -1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (if0.pb_pulse_o[1]) begin pulses++; if (first < 0) first = k; end
    end
    vectors++;
    if (pulses != 1) begin errors++; $display("FAIL mid_rst_pulses: got %0d expected 1", pulses); end
    vectors++;
    if (first != 10) begin errors++; $display("FAIL mid_rst_latency: got %0d expected 10", first); end
    pb[1] = 1'b1;
    repeat (14) @(negedge clk);
  endtask
  task automatic test_random;
    logic [7:0] mp;
    pb = 4'h0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 10) begin
        vectors++;
        if (if0.pb_pulse_o !== 4'hF) begin errors++; $display("FAIL simul_press: got %h expected f", if0.pb_pulse_o); end
      end
    end
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) mp[2*i+:2] = 2'(m_mode[i]);
      vectors++;
      if (if0.dipsw_db_o !== m_db) begin errors++; $display("FAIL rnd_db cycle %0d: got %h expected %h", c, if0.dipsw_db_o, m_db); end
      vectors++;
      if (if0.pb_pulse_o !== m_pulse) begin errors++; $display("FAIL rnd_pulse cycle %0d: got %h expected %h", c, if0.pb_pulse_o, m_pulse); end
      vectors++;
      if (if0.mode_o !== mp) begin errors++; $display("FAIL rnd_mode cycle %0d: got %h expected %h", c, if0.mode_o, mp); end
      vectors++;
      if (if0.USER_LED_FPGA !== ~m_led[0] || if1.USER_LED_FPGA !== ~m_led[1] || if2.USER_LED_FPGA !== ~m_led[2]) begin
        errors++;
        $display("FAIL rnd_led cycle %0d: got %h/%h/%h expected %h/%h/%h", c, if0.USER_LED_FPGA, if1.USER_LED_FPGA,
                 if2.USER_LED_FPGA, ~m_led[0], ~m_led[1], ~m_led[2]);
      end
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 11) == 0) dip[i] = ~dip[i];
        if ($urandom_range(0, 11) == 0) pb[i] = ~pb[i];
      end
    end
  endtask
  initial begin
    test_reset();
    test_debounce_dip();
    test_button();
    test_blink();
    test_pwm();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
